ucie_sb_link_checker: RTL and testbench
=======================================

UCIE_SB_LINK_CHECKER -- requirements
Module: ucie_sb_link_checker

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: independent sideband channels checked in parallel.
REQ-002 SHALL have parameter PKT_BITS, default 64: UIs per sideband packet.
REQ-003 SHALL have parameter CNT_W, default 16: width of per-channel packet and error counters.
REQ-004 SHALL have port clk  input  1  single clock; one clk cycle equals one UI.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port en  input  1  checker enable.
REQ-007 SHALL have port cfg_min_gap  input  8  minimum idle UIs between packets, sampled every cycle; spec value 32.
REQ-008 SHALL have port clr_sticky  input  1  clears err_sticky.
REQ-009 SHALL have port ui_valid  input  NUM_CH  per channel: SB clock toggled in this UI.
REQ-010 SHALL have port ui_data  input  NUM_CH  per channel: SB data bit for this UI.
REQ-011 SHALL have port pkt_done  output  NUM_CH  one-cycle pulse: full packet received.
REQ-012 SHALL have port pkt_data  output  NUM_CH*PKT_BITS  last captured packet per channel, first UI in bit 0.
REQ-013 SHALL have port err_short, err_gap, err_idle_data  output  NUM_CH each  one-cycle error pulses.
REQ-014 SHALL have port err_sticky  output  NUM_CH*3  per channel {idle_data, gap, short}, set on pulse.
REQ-015 SHALL have port pkt_cnt, err_cnt  output  NUM_CH*CNT_W each  saturating counters.

Function
REQ-016 SHALL run one FSM per channel with states IDLE, PKT, GAP, plus bit_cnt and gap_cnt (8-bit, saturating at 255).
REQ-017 SHALL, in IDLE with ui_valid=1, capture ui_data into bit 0, set bit_cnt=1, go PKT.
REQ-018 SHALL, in PKT with ui_valid=1, capture ui_data at index bit_cnt, increment bit_cnt; on the PKT_BITS-th bit go GAP with gap_cnt=0 and pulse pkt_done the next cycle with pkt_data updated that same cycle.
REQ-019 SHALL, in PKT with ui_valid=0, pulse err_short, discard the partial packet (pkt_data unchanged), go GAP with gap_cnt=1.
REQ-020 SHALL, in GAP with ui_valid=0, increment gap_cnt and go IDLE once the incremented value >= cfg_min_gap.
REQ-021 SHALL, in GAP with ui_valid=1, pulse err_gap when gap_cnt < cfg_min_gap, and in all cases start a new packet as in REQ-017.
REQ-022 SHALL treat cfg_min_gap=0 as no gap requirement: back-to-back packets raise no err_gap.
REQ-023 SHALL pulse err_idle_data whenever ui_valid=0 and ui_data=1, in any state; may coincide with err_short.
REQ-024 SHALL register all pulses: each asserts exactly one cycle after the offending sample.
REQ-025 SHALL increment pkt_cnt on each pkt_done, and err_cnt by exactly 1 on any cycle with one or more error pulses; both saturate at 2^CNT_W-1.
REQ-026 SHALL give set priority over clr_sticky when both occur in the same cycle.
REQ-027 SHALL, with en=0, force all FSMs to IDLE without error, suppress all pulses, hold counters, sticky bits and pkt_data.
REQ-028 SHALL keep channels fully independent; simultaneous events on different channels are handled in the same cycle.

Reset
REQ-029 SHALL, on reset assertion, immediately clear all FSMs to IDLE, bit_cnt, gap_cnt, pkt_data, counters, err_sticky and all pulse outputs to 0.
REQ-030 SHALL abort any in-flight packet on reset with no error reported after release.

Verification
REQ-031 Ch0: 64 valid UIs of pattern 0xA5A5_A5A5_A5A5_A5A5, then 32 idle, then a second packet -> pkt_done twice, pkt_data=0xA5A5_A5A5_A5A5_A5A5, pkt_cnt=2, no errors.
REQ-032 Ch1: 40 valid UIs then ui_valid=0 -> err_short 1 cycle after the first idle sample, err_sticky[short]=1, err_cnt=1, pkt_cnt=0.
REQ-033 Ch2, cfg_min_gap=32: packet, 20 idle UIs, new packet -> err_gap once, second packet still completes, pkt_cnt=2, err_cnt=1.
REQ-034 Ch3: ui_data=1 with ui_valid=0 for 3 UIs during a gap -> 3 err_idle_data pulses, err_cnt=3; clr_sticky on the 3rd error cycle leaves the sticky bit set.
REQ-035 All channels: reset mid-packet at bit 30, then release -> all outputs 0, no err_short; next full packet counts as pkt_cnt=1.
REQ-036 CNT_W=4: 20 packets on ch0 -> pkt_cnt saturates at 15; cfg_min_gap=0 with back-to-back packets -> no err_gap.

Source files
------------

// File: rtl/ucie_sb_link_checker.sv
// UCIe sideband link checker: per-channel packet framing with gap and idle-data
// checks, registered error pulses, sticky flags and saturating counters.
module ucie_sb_link_checker #(
    parameter int NUM_CH   = 4,
    parameter int PKT_BITS = 64,
    parameter int CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic [7:0]                 cfg_min_gap,
    input  logic                       clr_sticky,
    input  logic [NUM_CH-1:0]          ui_valid,
    input  logic [NUM_CH-1:0]          ui_data,
    output logic [NUM_CH-1:0]          pkt_done,
    output logic [NUM_CH*PKT_BITS-1:0] pkt_data,
    output logic [NUM_CH-1:0]          err_short,
    output logic [NUM_CH-1:0]          err_gap,
    output logic [NUM_CH-1:0]          err_idle_data,
    output logic [NUM_CH*3-1:0]        err_sticky,
    output logic [NUM_CH*CNT_W-1:0]    pkt_cnt,
    output logic [NUM_CH*CNT_W-1:0]    err_cnt
);
    localparam int BC_W = (PKT_BITS > 1) ? $clog2(PKT_BITS) : 1;
    localparam logic [BC_W-1:0] BIT_LAST = BC_W'(PKT_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PKT  = 2'd1,
        GAP  = 2'd2
    } state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        logic [CNT_W-1:0] res;
        if (val == CNT_MAX) begin
            res = CNT_MAX;
        end else begin
            res = val + CNT_W'(1);
        end
        return res;
    endfunction

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_e              state_q, state_d;
        logic [BC_W-1:0]     bit_cnt_q, bit_cnt_d;
        logic [7:0]          gap_cnt_q, gap_cnt_d, gap_inc_s;
        logic [PKT_BITS-1:0] cap_q, cap_d, pkt_data_q, pkt_data_d;
        logic                done_q, done_d, short_q, short_d;
        logic                gap_err_q, gap_err_d, idle_q, idle_d;
        logic [2:0]          sticky_q, sticky_d;
        logic [CNT_W-1:0]    pkt_cnt_q, pkt_cnt_d, err_cnt_q, err_cnt_d;
        logic                v_s, d_s;

        assign v_s       = ui_valid[g];
        assign d_s       = ui_data[g];
        assign gap_inc_s = (gap_cnt_q == 8'hFF) ? 8'hFF : (gap_cnt_q + 8'd1);

        // Next-state: framing FSM, capture buffer, pulses, sticky flags and counters
        always_comb begin
            state_d    = state_q;
            bit_cnt_d  = bit_cnt_q;
            gap_cnt_d  = gap_cnt_q;
            cap_d      = cap_q;
            pkt_data_d = pkt_data_q;
            done_d     = 1'b0;
            short_d    = 1'b0;
            gap_err_d  = 1'b0;
            idle_d     = 1'b0;
            sticky_d   = sticky_q;
            pkt_cnt_d  = pkt_cnt_q;
            err_cnt_d  = err_cnt_q;

            if (!en) begin
                state_d   = IDLE;
                bit_cnt_d = '0;
                gap_cnt_d = 8'd0;
            end else begin
                idle_d = ~v_s & d_s;
                case (state_q)
                    IDLE: begin
                        if (v_s) begin
                            cap_d[0]  = d_s;
                            bit_cnt_d = BC_W'(1);
                            state_d   = PKT;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                    PKT: begin
                        if (v_s) begin
                            cap_d[bit_cnt_q] = d_s;
                            if (bit_cnt_q == BIT_LAST) begin
                                pkt_data_d = cap_d;
                                done_d     = 1'b1;
                                bit_cnt_d  = '0;
                                gap_cnt_d  = 8'd0;
                                state_d    = GAP;
                            end else begin
                                bit_cnt_d = bit_cnt_q + BC_W'(1);
                            end
                        end else begin
                            // Partial packet is dropped; pkt_data keeps the last good one
                            short_d   = 1'b1;
                            bit_cnt_d = '0;
                            gap_cnt_d = 8'd1;
                            state_d   = GAP;
                        end
                    end
                    GAP: begin
                        if (v_s) begin
                            gap_err_d = (gap_cnt_q < cfg_min_gap);
                            cap_d[0]  = d_s;
                            bit_cnt_d = BC_W'(1);
                            state_d   = PKT;
                        end else begin
                            gap_cnt_d = gap_inc_s;
                            if (gap_inc_s >= cfg_min_gap) begin
                                state_d = IDLE;
                            end else begin
                                state_d = GAP;
                            end
                        end
                    end
                    default: begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                        gap_cnt_d = 8'd0;
                    end
                endcase

                // New error events win over a simultaneous clear
                sticky_d = ({3{~clr_sticky}} & sticky_q) | {idle_d, gap_err_d, short_d};
                if (done_d) begin
                    pkt_cnt_d = sat_inc(pkt_cnt_q);
                end else begin
                    pkt_cnt_d = pkt_cnt_q;
                end
                if (idle_d || gap_err_d || short_d) begin
                    err_cnt_d = sat_inc(err_cnt_q);
                end else begin
                    err_cnt_d = err_cnt_q;
                end
            end
        end

        // Channel state and output registers
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q    <= IDLE;
                bit_cnt_q  <= '0;
                gap_cnt_q  <= 8'd0;
                cap_q      <= '0;
                pkt_data_q <= '0;
                done_q     <= 1'b0;
                short_q    <= 1'b0;
                gap_err_q  <= 1'b0;
                idle_q     <= 1'b0;
                sticky_q   <= 3'b000;
                pkt_cnt_q  <= '0;
                err_cnt_q  <= '0;
            end else begin
                state_q    <= state_d;
                bit_cnt_q  <= bit_cnt_d;
                gap_cnt_q  <= gap_cnt_d;
                cap_q      <= cap_d;
                pkt_data_q <= pkt_data_d;
                done_q     <= done_d;
                short_q    <= short_d;
                gap_err_q  <= gap_err_d;
                idle_q     <= idle_d;
                sticky_q   <= sticky_d;
                pkt_cnt_q  <= pkt_cnt_d;
                err_cnt_q  <= err_cnt_d;
            end
        end

        assign pkt_done[g]                       = done_q;
        assign err_short[g]                      = short_q;
        assign err_gap[g]                        = gap_err_q;
        assign err_idle_data[g]                  = idle_q;
        assign pkt_data[g*PKT_BITS +: PKT_BITS]  = pkt_data_q;
        assign err_sticky[g*3 +: 3]              = sticky_q;
        assign pkt_cnt[g*CNT_W +: CNT_W]         = pkt_cnt_q;
        assign err_cnt[g*CNT_W +: CNT_W]         = err_cnt_q;
    end

endmodule

// File: tb/tb_ucie_sb_link_checker.sv
// Self-checking bench for ucie_sb_link_checker: vector table plus directed
// multi-cycle sequences, with expected pulses queued as stimulus is driven.
module tb_ucie_sb_link_checker;
    localparam int NUM_CH   = 4;
    localparam int PKT_BITS = 64;
    localparam int CNT_W    = 4;

    typedef struct packed {
        logic [3:0] done;
        logic [3:0] sh;
        logic [3:0] gp;
        logic [3:0] id;
    } exp_t;

    typedef struct {
        logic       en;
        logic [3:0] v;
        logic [3:0] d;
        logic       clr;
        logic [3:0] sh;
        logic [3:0] gp;
        logic [3:0] id;
        logic [11:0] sticky;
    } vec_t;

    logic                       clk;
    logic                       reset;
    logic                       en;
    logic [7:0]                 cfg_min_gap;
    logic                       clr_sticky;
    logic [NUM_CH-1:0]          ui_valid;
    logic [NUM_CH-1:0]          ui_data;
    logic [NUM_CH-1:0]          pkt_done;
    logic [NUM_CH*PKT_BITS-1:0] pkt_data;
    logic [NUM_CH-1:0]          err_short;
    logic [NUM_CH-1:0]          err_gap;
    logic [NUM_CH-1:0]          err_idle_data;
    logic [NUM_CH*3-1:0]        err_sticky;
    logic [NUM_CH*CNT_W-1:0]    pkt_cnt;
    logic [NUM_CH*CNT_W-1:0]    err_cnt;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb_q[$];
    logic [63:0] exp_pkt[4];
    vec_t        tbl[13];

    ucie_sb_link_checker #(
        .NUM_CH(NUM_CH),
        .PKT_BITS(PKT_BITS),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .cfg_min_gap(cfg_min_gap),
        .clr_sticky(clr_sticky),
        .ui_valid(ui_valid),
        .ui_data(ui_data),
        .pkt_done(pkt_done),
        .pkt_data(pkt_data),
        .err_short(err_short),
        .err_gap(err_gap),
        .err_idle_data(err_idle_data),
        .err_sticky(err_sticky),
        .pkt_cnt(pkt_cnt),
        .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] done, input logic [3:0] sh,
                                input logic [3:0] gp, input logic [3:0] id);
        exp_t e;
        e.done = done;
        e.sh   = sh;
        e.gp   = gp;
        e.id   = id;
        return e;
    endfunction

    // One UI: drive at negedge, pulses for this sample are visible by the next negedge
    task automatic apply(input logic [3:0] v, input logic [3:0] d, input logic c, input exp_t e);
        exp_t x;
        ui_valid   = v;
        ui_data    = d;
        clr_sticky = c;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        x = sb_q.pop_front();
        chk("pulses{done,short,gap,idle}",
            256'({pkt_done, err_short, err_gap, err_idle_data}), 256'(x));
        for (int c2 = 0; c2 < NUM_CH; c2++) begin
            if (x.done[c2]) begin
                chk($sformatf("pkt_data_ch%0d", c2), 256'(pkt_data[c2*64 +: 64]), 256'(exp_pkt[c2]));
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            apply(4'b0000, 4'b0000, 1'b0, mk(4'b0, 4'b0, 4'b0, 4'b0));
        end
    endtask

    task automatic send_pkts(input logic [3:0] mask, input logic [63:0] data,
                             input logic [3:0] gp, input logic [3:0] extra);
        for (int i = 0; i < 64; i++) begin
            if (i == 63) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (mask[c]) exp_pkt[c] = data;
                end
            end
            apply(mask, (mask & {4{data[i]}}) | ((i == 0) ? extra : 4'b0000), 1'b0,
                  mk((i == 63) ? mask : 4'b0, 4'b0, (i == 0) ? gp : 4'b0, (i == 0) ? extra : 4'b0));
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_pkt_data"}, pkt_data, 256'd0);
        chk({tag, "_flags_cnts"},
            256'({pkt_done, err_short, err_gap, err_idle_data, err_sticky, pkt_cnt, err_cnt}), 256'd0);
    endtask

    task automatic do_reset();
        ui_valid   = 4'b0000;
        ui_data    = 4'b0000;
        clr_sticky = 1'b0;
        reset      = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        for (int c = 0; c < NUM_CH; c++) exp_pkt[c] = 64'd0;
    endtask

    initial begin
        logic [63:0] d0;
        logic [63:0] d1;
        logic [63:0] dd;

        //           en    v        d        clr   short    gap      idle     sticky
        tbl[0]  = '{1'b1, 4'b0000, 4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0001, 12'h004};
        tbl[1]  = '{1'b1, 4'b0010, 4'b0010, 1'b0, 4'b0000, 4'b0000, 4'b0000, 12'h004};
        tbl[2]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0010, 4'b0000, 4'b0000, 12'h00C};
        tbl[3]  = '{1'b1, 4'b0010, 4'b0000, 1'b0, 4'b0000, 4'b0010, 4'b0000, 12'h01C};
        tbl[4]  = '{1'b1, 4'b0000, 4'b0010, 1'b0, 4'b0010, 4'b0000, 4'b0010, 12'h03C};
        tbl[5]  = '{1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 12'h000};
        tbl[6]  = '{1'b1, 4'b0010, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 12'h000};
        tbl[7]  = '{1'b1, 4'b0000, 4'b1000, 1'b1, 4'b0010, 4'b0000, 4'b1000, 12'h808};
        tbl[8]  = '{1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0000, 4'b0000, 4'b0000, 12'h808};
        tbl[9]  = '{1'b1, 4'b0010, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 12'h808};
        tbl[10] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 12'h808};
        tbl[11] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 12'h808};
        tbl[12] = '{1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 12'h000};

        reset       = 1'b1;
        en          = 1'b1;
        cfg_min_gap = 8'd32;
        clr_sticky  = 1'b0;
        ui_valid    = 4'b0000;
        ui_data     = 4'b0000;
        for (int c = 0; c < NUM_CH; c++) exp_pkt[c] = 64'd0;
        @(negedge clk);
        @(negedge clk);
        check_zero("init");
        reset = 1'b0;

        // Short-packet, gap, idle-data, sticky priority and enable behaviour
        cfg_min_gap = 8'd2;
        for (int i = 0; i < 13; i++) begin
            en = tbl[i].en;
            apply(tbl[i].v, tbl[i].d, tbl[i].clr, mk(4'b0, tbl[i].sh, tbl[i].gp, tbl[i].id));
            chk($sformatf("tbl%0d_sticky", i), 256'(err_sticky), 256'(tbl[i].sticky));
        end
        en = 1'b1;
        chk("tbl_err_cnt", 256'(err_cnt), 256'(16'h1041));
        chk("tbl_pkt_cnt", 256'(pkt_cnt), 256'(16'h0000));
        cfg_min_gap = 8'd32;

        // Ch0: two clean packets separated by exactly the minimum gap
        do_reset();
        send_pkts(4'b0001, 64'hA5A5_A5A5_A5A5_A5A5, 4'b0, 4'b0);
        idle(32);
        send_pkts(4'b0001, 64'hA5A5_A5A5_A5A5_A5A5, 4'b0, 4'b0);
        chk("c0_pkt_cnt", 256'(pkt_cnt), 256'(16'h0002));
        chk("c0_err_cnt", 256'(err_cnt), 256'(16'h0000));
        chk("c0_pkt_data", 256'(pkt_data[63:0]), 256'(64'hA5A5_A5A5_A5A5_A5A5));

        // Ch1 truncated after 40 UIs while ch0 completes a packet in parallel
        do_reset();
        d0 = 64'h0123_4567_89AB_CDEF;
        d1 = {$urandom, $urandom};
        exp_pkt[0] = d0;
        for (int i = 0; i < 64; i++) begin
            apply({2'b00, (i < 40), 1'b1}, {2'b00, (i < 40) ? d1[i] : 1'b0, d0[i]}, 1'b0,
                  mk((i == 63) ? 4'b0001 : 4'b0, (i == 40) ? 4'b0010 : 4'b0, 4'b0, 4'b0));
        end
        chk("c1_sticky", 256'(err_sticky), 256'(12'h008));
        chk("c1_err_cnt", 256'(err_cnt), 256'(16'h0010));
        chk("c1_pkt_cnt", 256'(pkt_cnt), 256'(16'h0001));
        chk("c1_pkt_data_kept", 256'(pkt_data[127:64]), 256'(64'd0));

        // Ch2: gap too short, second packet still completes
        do_reset();
        send_pkts(4'b0100, {$urandom, $urandom}, 4'b0, 4'b0);
        idle(20);
        send_pkts(4'b0100, {$urandom, $urandom}, 4'b0100, 4'b0);
        chk("c2_pkt_cnt", 256'(pkt_cnt), 256'(16'h0200));
        chk("c2_err_cnt", 256'(err_cnt), 256'(16'h0100));
        chk("c2_sticky", 256'(err_sticky), 256'(12'h080));

        // Ch3: idle-data errors in the gap, clear coinciding with the third one
        do_reset();
        send_pkts(4'b1000, 64'hDEAD_BEEF_0F0F_3C3C, 4'b0, 4'b0);
        apply(4'b0000, 4'b1000, 1'b0, mk(4'b0, 4'b0, 4'b0, 4'b1000));
        apply(4'b0000, 4'b1000, 1'b0, mk(4'b0, 4'b0, 4'b0, 4'b1000));
        apply(4'b0000, 4'b1000, 1'b1, mk(4'b0, 4'b0, 4'b0, 4'b1000));
        chk("c3_err_cnt", 256'(err_cnt), 256'(16'h3000));
        chk("c3_sticky_set_wins", 256'(err_sticky), 256'(12'h800));
        apply(4'b0000, 4'b0000, 1'b1, mk(4'b0, 4'b0, 4'b0, 4'b0));
        chk("c3_sticky_cleared", 256'(err_sticky), 256'(12'h000));
        chk("c3_pkt_cnt", 256'(pkt_cnt), 256'(16'h1000));
        idle(40);

        // All channels: asynchronous reset at bit 30 of an in-flight packet
        dd = {$urandom, $urandom};
        for (int i = 0; i < 30; i++) begin
            apply(4'b1111, {4{dd[i]}}, 1'b0, mk(4'b0, 4'b0, 4'b0, 4'b0));
        end
        reset = 1'b1;
        #1;
        check_zero("async_reset");
        ui_valid = 4'b0000;
        ui_data  = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < NUM_CH; c++) exp_pkt[c] = 64'd0;
        idle(5);
        send_pkts(4'b1111, {$urandom, $urandom}, 4'b0, 4'b0);
        chk("abort_pkt_cnt", 256'(pkt_cnt), 256'(16'h1111));
        chk("abort_err_cnt", 256'(err_cnt), 256'(16'h0000));

        // Back-to-back packets with no gap requirement; counters saturate
        do_reset();
        cfg_min_gap = 8'd0;
        for (int p = 0; p < 20; p++) begin
            send_pkts(4'b0001, {$urandom, $urandom}, 4'b0, 4'b1000);
        end
        chk("sat_pkt_cnt", 256'(pkt_cnt), 256'(16'h000F));
        chk("sat_err_cnt", 256'(err_cnt), 256'(16'hF000));
        chk("sat_sticky", 256'(err_sticky), 256'(12'h800));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
